// File: rtl/memory_cycle.sv
// MEM pipeline stage: issues data-memory loads/stores over a req/ack handshake,
// stalls upstream while an access is outstanding and registers results for write-back.
module memory_cycle #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] aluin,
  input  logic [15:0] bin,
  input  logic [3:0]  rdin,
  input  logic        regwrite,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        memtoreg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [15:0] wbdata,
  output logic [3:0]  rdout,
  output logic        regwriteout,
  output logic        valid_out,
  output logic        fault
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [15:0] LastCount = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] wbdata_q, wbdata_d;
  logic [3:0]  rdout_q, rdout_d;
  logic        regwriteout_q, regwriteout_d;
  logic        valid_out_q, valid_out_d;
  logic        fault_q, fault_d;
  logic [3:0]  rd_cap_q, rd_cap_d;
  logic        regwrite_cap_q, regwrite_cap_d;
  logic        memtoreg_cap_q, memtoreg_cap_d;
  logic [15:0] alu_cap_q, alu_cap_d;

  logic mem_op;
  logic illegal_op;

  assign mem_op     = memread | memwrite;
  assign illegal_op = (memread & memwrite) | (mem_op & aluin[0]);

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    wbdata_d       = wbdata_q;
    rdout_d        = rdout_q;
    regwriteout_d  = regwriteout_q;
    valid_out_d    = 1'b0;
    fault_d        = fault_q;
    rd_cap_d       = rd_cap_q;
    regwrite_cap_d = regwrite_cap_q;
    memtoreg_cap_d = memtoreg_cap_q;
    alu_cap_d      = alu_cap_q;

    case (state_q)
      IDLE: begin
        regwriteout_d = 1'b0;
        if (valid_in) begin
          if (illegal_op) begin
            fault_d     = 1'b1;
            valid_out_d = 1'b1;
            rdout_d     = rdin;
            wbdata_d    = aluin;
          end else if (mem_op) begin
            rd_cap_d       = rdin;
            regwrite_cap_d = regwrite;
            memtoreg_cap_d = memtoreg;
            alu_cap_d      = aluin;
            mem_addr_d     = aluin[15:1];
            mem_wdata_d    = bin;
            mem_we_d       = memwrite;
            mem_req_d      = 1'b1;
            count_d        = 16'd0;
            state_d        = ACCESS;
          end else begin
            wbdata_d      = aluin;
            rdout_d       = rdin;
            regwriteout_d = regwrite;
            valid_out_d   = 1'b1;
          end
        end
      end

      ACCESS: begin
        // An ack arriving on the final counted cycle still completes the access.
        if (mem_ack) begin
          mem_req_d     = 1'b0;
          wbdata_d      = memtoreg_cap_q ? mem_rdata : alu_cap_q;
          rdout_d       = rd_cap_q;
          regwriteout_d = regwrite_cap_q;
          valid_out_d   = 1'b1;
          state_d       = IDLE;
        end else if (count_q == LastCount) begin
          mem_req_d     = 1'b0;
          fault_d       = 1'b1;
          valid_out_d   = 1'b1;
          regwriteout_d = 1'b0;
          state_d       = IDLE;
        end else begin
          count_d = count_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      count_q        <= 16'd0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 15'd0;
      mem_wdata_q    <= 16'd0;
      wbdata_q       <= 16'd0;
      rdout_q        <= 4'd0;
      regwriteout_q  <= 1'b0;
      valid_out_q    <= 1'b0;
      fault_q        <= 1'b0;
      rd_cap_q       <= 4'd0;
      regwrite_cap_q <= 1'b0;
      memtoreg_cap_q <= 1'b0;
      alu_cap_q      <= 16'd0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      wbdata_q       <= wbdata_d;
      rdout_q        <= rdout_d;
      regwriteout_q  <= regwriteout_d;
      valid_out_q    <= valid_out_d;
      fault_q        <= fault_d;
      rd_cap_q       <= rd_cap_d;
      regwrite_cap_q <= regwrite_cap_d;
      memtoreg_cap_q <= memtoreg_cap_d;
      alu_cap_q      <= alu_cap_d;
    end
  end

  assign stall       = (state_q == ACCESS);
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign wbdata      = wbdata_q;
  assign rdout       = rdout_q;
  assign regwriteout = regwriteout_q;
  assign valid_out   = valid_out_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: pass-through, load, store, misaligned,
// timeout and reset-during-access scenarios with hand-computed expectations.
module tb_memory_cycle;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [15:0] aluin;
  logic [15:0] bin;
  logic [3:0]  rdin;
  logic        regwrite;
  logic        memread;
  logic        memwrite;
  logic        memtoreg;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic [15:0] wbdata;
  logic [3:0]  rdout;
  logic        regwriteout;
  logic        valid_out;
  logic        fault;

  int checkCount = 0;
  int errorCount = 0;

  memory_cycle #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .aluin      (aluin),
    .bin        (bin),
    .rdin       (rdin),
    .regwrite   (regwrite),
    .memread    (memread),
    .memwrite   (memwrite),
    .memtoreg   (memtoreg),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .stall      (stall),
    .wbdata     (wbdata),
    .rdout      (rdout),
    .regwriteout(regwriteout),
    .valid_out  (valid_out),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] rd, input logic rw, input logic mr,
                               input logic mw, input logic mt);
    valid_in = v;
    aluin    = a;
    bin      = b;
    rdin     = rd;
    regwrite = rw;
    memread  = mr;
    memwrite = mw;
    memtoreg = mt;
  endtask

  initial begin
    rst       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    stepClock();
    stepClock();
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_wbdata", wbdata, 0);
    checkOutput("rst_rdout", rdout, 0);
    checkOutput("rst_regwriteout", regwriteout, 0);
    checkOutput("rst_valid_out", valid_out, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_stall", stall, 0);

    // Pass-through ALU op
    rst = 1'b1;
    applyStimulus(1'b1, 16'h1234, 16'h0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    stepClock();
    checkOutput("pt_wbdata", wbdata, 32'h1234);
    checkOutput("pt_rdout", rdout, 5);
    checkOutput("pt_regwriteout", regwriteout, 1);
    checkOutput("pt_valid_out", valid_out, 1);
    checkOutput("pt_stall", stall, 0);

    // Load with ack on third ACCESS cycle
    applyStimulus(1'b1, 16'h0040, 16'h0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    stepClock();
    checkOutput("ld_mem_req", mem_req, 1);
    checkOutput("ld_mem_addr", mem_addr, 32'h0020);
    checkOutput("ld_mem_we", mem_we, 0);
    checkOutput("ld_stall1", stall, 1);
    checkOutput("ld_valid_wait", valid_out, 0);
    applyStimulus(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    checkOutput("ld_stall2", stall, 1);
    stepClock();
    checkOutput("ld_stall3", stall, 1);
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    stepClock();
    mem_ack   = 1'b0;
    checkOutput("ld_wbdata", wbdata, 32'hBEEF);
    checkOutput("ld_rdout", rdout, 7);
    checkOutput("ld_regwriteout", regwriteout, 1);
    checkOutput("ld_valid_out", valid_out, 1);
    checkOutput("ld_mem_req_done", mem_req, 0);
    checkOutput("ld_stall_done", stall, 0);
    stepClock();
    checkOutput("ld_valid_one_cycle", valid_out, 0);

    // Store followed by an ALU op held on the inputs
    applyStimulus(1'b1, 16'h0010, 16'hA5A5, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    stepClock();
    checkOutput("st_mem_we", mem_we, 1);
    checkOutput("st_mem_wdata", mem_wdata, 32'hA5A5);
    checkOutput("st_mem_addr", mem_addr, 32'h0008);
    checkOutput("st_mem_req", mem_req, 1);
    applyStimulus(1'b1, 16'h0777, 16'h0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b1;
    stepClock();
    mem_ack = 1'b0;
    checkOutput("st_valid_out", valid_out, 1);
    checkOutput("st_regwriteout", regwriteout, 0);
    checkOutput("st_wbdata", wbdata, 32'h0010);
    checkOutput("st_mem_req_done", mem_req, 0);
    stepClock();
    checkOutput("alu_wbdata", wbdata, 32'h0777);
    checkOutput("alu_rdout", rdout, 9);
    checkOutput("alu_regwriteout", regwriteout, 1);
    checkOutput("alu_valid_out", valid_out, 1);
    applyStimulus(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    checkOutput("idle_valid_out", valid_out, 0);
    checkOutput("idle_regwriteout", regwriteout, 0);

    // Misaligned load raises sticky fault without a request
    applyStimulus(1'b1, 16'h0041, 16'h0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    stepClock();
    checkOutput("mis_mem_req", mem_req, 0);
    checkOutput("mis_fault", fault, 1);
    checkOutput("mis_valid_out", valid_out, 1);
    checkOutput("mis_regwriteout", regwriteout, 0);
    checkOutput("mis_rdout", rdout, 2);
    checkOutput("mis_wbdata", wbdata, 32'h0041);
    applyStimulus(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b1;
    stepClock();
    mem_ack = 1'b0;
    checkOutput("mis_fault_sticky", fault, 1);
    checkOutput("idle_ack_ignored", valid_out, 0);
    checkOutput("mis_no_req", mem_req, 0);
    rst = 1'b0;
    stepClock();
    rst = 1'b1;
    checkOutput("fault_cleared", fault, 0);

    // Timeout: no ack, TIMEOUT = 4
    applyStimulus(1'b1, 16'h0100, 16'h0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    stepClock();
    checkOutput("to_req_c1", mem_req, 1);
    applyStimulus(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      stepClock();
      checkOutput($sformatf("to_req_c%0d", i), mem_req, 1);
      checkOutput($sformatf("to_valid_c%0d", i), valid_out, 0);
    end
    stepClock();
    checkOutput("to_req_dropped", mem_req, 0);
    checkOutput("to_fault", fault, 1);
    checkOutput("to_valid_out", valid_out, 1);
    checkOutput("to_regwriteout", regwriteout, 0);
    checkOutput("to_stall", stall, 0);

    // Reset during the second cycle of an access overrides a concurrent ack
    applyStimulus(1'b1, 16'h0200, 16'h0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    stepClock();
    checkOutput("rm_req", mem_req, 1);
    applyStimulus(1'b0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    checkOutput("rm_stall_c2", stall, 1);
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 16'h5555;
    stepClock();
    checkOutput("rm_mem_req", mem_req, 0);
    checkOutput("rm_stall", stall, 0);
    checkOutput("rm_valid_out", valid_out, 0);
    checkOutput("rm_fault", fault, 0);
    rst     = 1'b1;
    mem_ack = 1'b0;
    stepClock();
    checkOutput("rm_after_valid", valid_out, 0);
    checkOutput("rm_after_req", mem_req, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
